// File: rtl/ysyx_23060236_btb_update.sv
// EXU-side BTB writer: resolves each branch/jump against the IFU's predicted next PC,
// writes taken mispredicts into the BTB, pulses a flush and holds a redirect until the IFU accepts it.
module ysyx_23060236_btb_update #(
  parameter int ADDR_LEN = 25,
  parameter int DATA_LEN = 32,
  parameter int CNT_LEN  = 32
) (
  input  logic                clock,
  input  logic                reset,

  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_LEN-1:0] in_pc,
  input  logic                in_taken,
  input  logic [DATA_LEN-1:0] in_target,
  input  logic [DATA_LEN-1:0] in_pred_npc,

  output logic                btb_wvalid,
  output logic [ADDR_LEN-1:0] btb_awaddr,
  output logic [DATA_LEN-1:0] btb_wdata,

  output logic                flush,

  output logic                redirect_valid,
  input  logic                redirect_ready,
  output logic [DATA_LEN-1:0] redirect_pc,

  output logic [CNT_LEN-1:0]  br_cnt,
  output logic [CNT_LEN-1:0]  miss_cnt
);

  typedef enum logic {
    IDLE  = 1'b0,
    REDIR = 1'b1
  } state_e;

  localparam logic [DATA_LEN-1:0] PC_STEP = DATA_LEN'(4);

  state_e              state_q;
  state_e              state_d;
  logic                fire;
  logic                miss_fire;
  logic [DATA_LEN-1:0] actual_npc;

  assign in_ready       = (state_q == IDLE);
  assign redirect_valid = (state_q == REDIR);
  assign fire           = in_valid && in_ready;

  // Sequential fall-through wraps naturally at the top of the address space.
  assign actual_npc = in_taken ? in_target : in_pc + PC_STEP;
  assign miss_fire  = fire && (actual_npc != in_pred_npc);

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (miss_fire)      state_d = REDIR;
      REDIR:   if (redirect_ready) state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      btb_wvalid  <= 1'b0;
      btb_awaddr  <= '0;
      btb_wdata   <= '0;
      flush       <= 1'b0;
      redirect_pc <= '0;
      br_cnt      <= '0;
      miss_cnt    <= '0;
    end else begin
      state_q    <= state_d;
      btb_wvalid <= miss_fire && in_taken;
      flush      <= miss_fire;

      // A not-taken mispredict is a stale BTB hit; only the redirect repairs the path.
      if (miss_fire && in_taken) begin
        btb_awaddr <= in_pc[ADDR_LEN-1:0];
        btb_wdata  <= in_target;
      end

      if (miss_fire) redirect_pc <= actual_npc;

      // Statistics counters stick at all-ones instead of wrapping.
      if (fire && (br_cnt != '1))        br_cnt   <= br_cnt + CNT_LEN'(1);
      if (miss_fire && (miss_cnt != '1)) miss_cnt <= miss_cnt + CNT_LEN'(1);
    end
  end

endmodule

// File: tb/tb_ysyx_23060236_btb_update.sv
// Self-checking bench for ysyx_23060236_btb_update: directed vector table, hand-written
// corner sequences and random traffic, all compared against a queue-based reference model.
module tb_ysyx_23060236_btb_update;

  localparam int ADDR_LEN = 25;
  localparam int DATA_LEN = 32;
  localparam int CNT_LEN  = 6;

  logic                clock = 1'b0;
  logic                reset;
  logic                in_valid;
  logic                in_ready;
  logic [DATA_LEN-1:0] in_pc;
  logic                in_taken;
  logic [DATA_LEN-1:0] in_target;
  logic [DATA_LEN-1:0] in_pred_npc;
  logic                btb_wvalid;
  logic [ADDR_LEN-1:0] btb_awaddr;
  logic [DATA_LEN-1:0] btb_wdata;
  logic                flush;
  logic                redirect_valid;
  logic                redirect_ready;
  logic [DATA_LEN-1:0] redirect_pc;
  logic [CNT_LEN-1:0]  br_cnt;
  logic [CNT_LEN-1:0]  miss_cnt;

  ysyx_23060236_btb_update #(
    .ADDR_LEN(ADDR_LEN),
    .DATA_LEN(DATA_LEN),
    .CNT_LEN (CNT_LEN)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_pc         (in_pc),
    .in_taken      (in_taken),
    .in_target     (in_target),
    .in_pred_npc   (in_pred_npc),
    .btb_wvalid    (btb_wvalid),
    .btb_awaddr    (btb_awaddr),
    .btb_wdata     (btb_wdata),
    .flush         (flush),
    .redirect_valid(redirect_valid),
    .redirect_ready(redirect_ready),
    .redirect_pc   (redirect_pc),
    .br_cnt        (br_cnt),
    .miss_cnt      (miss_cnt)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: pending redirects live in a queue; the IFU pops one when it accepts.
  logic [DATA_LEN-1:0] rq[$];
  logic                m_wv, m_fl;
  logic [ADDR_LEN-1:0] m_aw;
  logic [DATA_LEN-1:0] m_wd;
  int                  m_br, m_miss;
  localparam int CNT_MAX = (1 << CNT_LEN) - 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_pre();
    logic [DATA_LEN-1:0] npc;
    logic acc, miss;
    if (!reset) begin
      rq.delete();
      m_wv = 1'b0; m_fl = 1'b0; m_br = 0; m_miss = 0;
    end else begin
      acc  = in_valid && (rq.size() == 0);
      npc  = in_taken ? in_target : in_pc + 32'd4;
      miss = acc && (npc != in_pred_npc);
      m_wv = miss && in_taken;
      m_fl = miss;
      if (m_wv) begin
        m_aw = in_pc[ADDR_LEN-1:0];
        m_wd = in_target;
      end
      if (rq.size() != 0 && redirect_ready) void'(rq.pop_front());
      if (miss) rq.push_back(npc);
      if (acc && m_br < CNT_MAX) m_br++;
      if (miss && m_miss < CNT_MAX) m_miss++;
    end
  endtask

  task automatic compare_all();
    check("in_ready",       in_ready,       rq.size() == 0);
    check("redirect_valid", redirect_valid, rq.size() != 0);
    check("flush",          flush,          m_fl);
    check("btb_wvalid",     btb_wvalid,     m_wv);
    check("br_cnt",         br_cnt,         m_br);
    check("miss_cnt",       miss_cnt,       m_miss);
    if (m_wv) begin
      check("btb_awaddr", btb_awaddr, m_aw);
      check("btb_wdata",  btb_wdata,  m_wd);
    end
    if (rq.size() != 0) check("redirect_pc", redirect_pc, rq[0]);
  endtask

  // One clock: model consumes the pre-edge inputs, DUT outputs are sampled 1 ns after the edge.
  task automatic cycle();
    model_pre();
    @(posedge clock);
    #1;
    compare_all();
  endtask

  task automatic drive(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                       input logic [31:0] pred);
    in_valid = 1'b1; in_pc = pc; in_taken = tk; in_target = tgt; in_pred_npc = pred;
  endtask

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
    logic [31:0] pred;
    int          hold;
    logic        exp_miss;
    logic        exp_wr;
    logic [24:0] exp_awaddr;
    logic [31:0] exp_rpc;
  } vec_t;

  vec_t vt[5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] br0;
    reset = 1'b0; in_valid = 1'b0; in_pc = '0; in_taken = 1'b0;
    in_target = '0; in_pred_npc = '0; redirect_ready = 1'b0;

    repeat (2) cycle();
    check("rst_redirect_pc", redirect_pc, 32'h0);
    check("rst_btb_awaddr",  btb_awaddr,  25'h0);
    check("rst_btb_wdata",   btb_wdata,   32'h0);
    reset = 1'b1;
    cycle();

    vt[0] = '{32'h80000010, 1'b1, 32'h80000100, 32'h80000100, 0, 1'b0, 1'b0, 25'h0,       32'h0};
    vt[1] = '{32'h80000020, 1'b1, 32'h80000400, 32'h80000024, 3, 1'b1, 1'b1, 25'h0000020, 32'h80000400};
    vt[2] = '{32'h80000030, 1'b0, 32'h12345678, 32'h80000400, 1, 1'b1, 1'b0, 25'h0,       32'h80000034};
    vt[3] = '{32'hFFFFFFFC, 1'b0, 32'h00000000, 32'h00000000, 0, 1'b0, 1'b0, 25'h0,       32'h0};
    vt[4] = '{32'hFFFFFFFC, 1'b0, 32'h00000000, 32'h00000004, 0, 1'b1, 1'b0, 25'h0,       32'h00000000};

    for (int i = 0; i < 5; i++) begin
      drive(vt[i].pc, vt[i].taken, vt[i].target, vt[i].pred);
      redirect_ready = 1'b0;
      cycle();
      in_valid = 1'b0;
      check("tv_flush",  flush,          vt[i].exp_miss);
      check("tv_wvalid", btb_wvalid,     vt[i].exp_wr);
      check("tv_rvalid", redirect_valid, vt[i].exp_miss);
      if (vt[i].exp_wr) begin
        check("tv_awaddr", btb_awaddr, vt[i].exp_awaddr);
        check("tv_wdata",  btb_wdata,  vt[i].target);
      end
      if (vt[i].exp_miss) begin
        check("tv_rpc", redirect_pc, vt[i].exp_rpc);
        for (int h = 0; h < vt[i].hold; h++) begin
          cycle();
          check("tv_hold_rvalid", redirect_valid, 1'b1);
          check("tv_hold_ready",  in_ready,       1'b0);
          check("tv_hold_flush",  flush,          1'b0);
          check("tv_hold_rpc",    redirect_pc,    vt[i].exp_rpc);
        end
        redirect_ready = 1'b1;
        cycle();
        redirect_ready = 1'b0;
        check("tv_release_ready", in_ready, 1'b1);
      end
    end
    check("tv_br_cnt",   br_cnt,   5);
    check("tv_miss_cnt", miss_cnt, 3);

    // Back-to-back: ready in the first REDIR cycle, next transfer lands in the following IDLE cycle.
    drive(32'h80000040, 1'b1, 32'h80000800, 32'h80000044);
    cycle();
    br0 = 8'(br_cnt);
    drive(32'h80000800, 1'b0, 32'h0, 32'h80000804);
    redirect_ready = 1'b1;
    cycle();
    redirect_ready = 1'b0;
    check("b2b_idle", in_ready, 1'b1);
    check("b2b_no_accept_in_redir", br_cnt, br0);
    cycle();
    in_valid = 1'b0;
    check("b2b_accept", br_cnt, br0 + 8'd1);

    // Saturation: many correct predictions, then many immediately released misses.
    for (int i = 0; i < 70; i++) begin
      drive(32'h80001000 + 32'(i * 4), 1'b0, 32'h0, 32'h80001004 + 32'(i * 4));
      cycle();
    end
    check("sat_br_cnt", br_cnt, CNT_MAX);
    redirect_ready = 1'b1;
    for (int i = 0; i < 70; i++) begin
      drive(32'h80002000, 1'b1, 32'h80003000 + 32'(i * 16), 32'h80002004);
      cycle();
      in_valid = 1'b0;
      cycle();
    end
    redirect_ready = 1'b0;
    check("sat_miss_cnt", miss_cnt, CNT_MAX);
    check("sat_br_hold",  br_cnt,   CNT_MAX);

    // Reset during REDIR abandons the redirect and clears counters.
    drive(32'h80000050, 1'b0, 32'h0, 32'h12345678);
    cycle();
    in_valid = 1'b0;
    check("mid_redir", redirect_valid, 1'b1);
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    check("rr_rvalid", redirect_valid, 1'b0);
    check("rr_ready",  in_ready,       1'b1);
    check("rr_br",     br_cnt,         0);
    check("rr_miss",   miss_cnt,       0);
    check("rr_rpc",    redirect_pc,    32'h0);

    // Reset beats a simultaneous transfer.
    drive(32'h80000060, 1'b1, 32'h80000900, 32'h80000064);
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    in_valid = 1'b0;
    check("rst_vs_xfer_br",    br_cnt,         0);
    check("rst_vs_xfer_rvalid", redirect_valid, 1'b0);
    cycle();

    // Random traffic; EXU holds its request until accepted.
    for (int i = 0; i < 600; i++) begin
      if (!(in_valid && rq.size() != 0)) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        in_pc     = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFC : ($urandom & 32'hFFFFFFFC);
        in_taken  = $urandom_range(0, 1) != 0;
        in_target = $urandom & 32'hFFFFFFFC;
        if ($urandom_range(0, 1) != 0)
          in_pred_npc = in_taken ? in_target : in_pc + 32'd4;
        else
          in_pred_npc = $urandom & 32'hFFFFFFFC;
      end
      redirect_ready = $urandom_range(0, 2) == 0;
      cycle();
      if (in_valid && rq.size() == 0 && !m_fl) in_valid = 1'b0;
      if (m_fl) in_valid = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ysyx_23060236_btb_update.md
Name: ysyx_23060236_btb_update

Overview:
- EXU-side writer for the branch target buffer.
- Accepts each resolved control-transfer instruction from EXU and compares the real next PC with the next PC the IFU fetched.
- On a misprediction it issues a one-cycle BTB write (taken branches only), a pipeline flush pulse and a held redirect request to the IFU.
- Keeps saturating branch and mispredict counters for performance statistics.

Parameters:
- ADDR_LEN, 25: BTB address width; the low bits of the PC that are written to btb_awaddr.
- DATA_LEN, 32: PC/target width.
- CNT_LEN, 32: width of the statistics counters.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset (reset==0 resets on a clock edge).
- in_valid  input  1  EXU presents a resolved branch/jump.
- in_ready  output  1  block can accept; combinational, equals (state==IDLE).
- in_pc  input  DATA_LEN  PC of the branch/jump.
- in_taken  input  1  branch actually taken (always 1 for jumps).
- in_target  input  DATA_LEN  actual taken target.
- in_pred_npc  input  DATA_LEN  next PC the IFU used for this instruction.
- btb_wvalid  output  1  one-cycle BTB write strobe.
- btb_awaddr  output  ADDR_LEN  BTB write address, in_pc[ADDR_LEN-1:0].
- btb_wdata  output  DATA_LEN  BTB write data, in_target.
- flush  output  1  one-cycle pulse that squashes younger IFU/IDU work.
- redirect_valid  output  1  redirect request to the IFU.
- redirect_ready  input  1  IFU accepts the redirect.
- redirect_pc  output  DATA_LEN  correct next PC.
- br_cnt  output  CNT_LEN  number of accepted branches.
- miss_cnt  output  CNT_LEN  number of mispredictions.

Behaviour:
- Handshake: a transfer occurs on a clock edge where in_valid && in_ready.
- Arithmetic:
  - actual_npc = in_taken ? in_target : in_pc + 4, truncated to DATA_LEN (0xFFFFFFFC + 4 wraps to 0).
  - mispredict = (actual_npc != in_pred_npc), full DATA_LEN compare.
- FSM has two states, IDLE and REDIR.
- IDLE:
  - in_ready = 1, redirect_valid = 0.
  - On a transfer with mispredict: go to REDIR; latch redirect_pc = actual_npc.
  - On a transfer without mispredict: stay in IDLE; no write, no flush, no redirect.
- REDIR:
  - in_ready = 0, redirect_valid = 1; redirect_pc is held stable.
  - On redirect_ready == 1: go to IDLE next cycle. A new transfer is possible in that IDLE cycle.
  - If redirect_ready is already 1 in the first REDIR cycle, REDIR lasts exactly one cycle.
  - A redirect is never dropped or reissued.
- Write and flush timing (registered, latency 1):
  - btb_wvalid = 1 in the cycle after a transfer with mispredict && in_taken.
  - btb_awaddr and btb_wdata are registered in the same cycle and are valid while btb_wvalid is high.
  - A not-taken mispredict (stale BTB hit) produces no write; the redirect alone corrects the path.
  - flush = 1 in the cycle after every mispredicting transfer, i.e. the first REDIR cycle. It is high for exactly one cycle, independent of redirect_ready.
- Counters:
  - br_cnt increments by 1 on every transfer.
  - miss_cnt increments by 1 on every mispredicting transfer.
  - Both saturate at all-ones and do not wrap.
- Reset (reset==0 at an edge):
  - state = IDLE; btb_wvalid, flush, redirect_valid = 0.
  - redirect_pc, btb_awaddr, btb_wdata = 0; br_cnt, miss_cnt = 0.
  - A reset during REDIR abandons the pending redirect.
  - Reset overrides a simultaneous transfer: counters are not incremented.
- in_valid while in REDIR is ignored (in_ready=0). EXU must hold its inputs until accepted.

Test Plan:
- Correct taken prediction: in_pc=0x80000010, taken, target=0x80000100, pred=0x80000100 -> no btb_wvalid/flush/redirect; br_cnt=1, miss_cnt=0.
- Taken miss: in_pc=0x80000020, taken, target=0x80000400, pred=0x80000024 -> next cycle btb_wvalid=1, btb_awaddr=0x0000020 (25-bit), btb_wdata=0x80000400, flush=1, redirect_valid=1, redirect_pc=0x80000400; redirect_ready held 0 for 3 cycles -> redirect_valid and in_ready=0 held for 3 cycles, flush high only the first cycle.
- Not-taken miss: in_pc=0x80000030, not taken, pred=0x80000400 -> redirect_pc=0x80000034, flush=1, btb_wvalid stays 0; miss_cnt increments.
- Wrap: in_pc=0xFFFFFFFC, not taken, pred=0x00000000 -> no mispredict; pred=0x00000004 -> redirect_pc=0x00000000.
- Back-to-back: redirect_ready=1 in the first REDIR cycle -> IDLE next cycle, and a second transfer is accepted in that cycle; counters preload near all-ones -> both saturate at all-ones.
- Reset mid-REDIR: reset=0 for one edge during REDIR -> redirect_valid=0, in_ready=1, counters=0 on the next cycle.
